// File: rtl/twos_comp_serial_unit_pkg.sv
// ---------------------------------------------------------------------------
// twos_comp_pkg
// Shared definitions for the digit-serial two's-complement unit:
//   - 2-bit operation mode codes (PASS, NEG, ABS, SM2TC)
//   - FSM state encoding (IDLE, RUN, DONE)
//   - idx_width(): width of the digit index register for a given digit count
// ---------------------------------------------------------------------------
package twos_comp_pkg;

   localparam logic [1:0] MODE_PASS  = 2'b00;
   localparam logic [1:0] MODE_NEG   = 2'b01;
   localparam logic [1:0] MODE_ABS   = 2'b10;
   localparam logic [1:0] MODE_SM2TC = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // A single-digit configuration still needs a 1-bit index register.
   function automatic int idx_width(input int ndig);
      return (ndig > 1) ? $clog2(ndig) : 1;
   endfunction

endpackage

// File: rtl/twos_comp_serial_unit_if.sv
// ---------------------------------------------------------------------------
// twos_comp_serial_unit_if
// Operand/result handshake bundle of the two's-complement unit.
//   in_valid/in_ready/in_data/in_mode    : operand channel (master -> unit)
//   out_valid/out_ready/out_data/out_neg/out_ovf : result channel (unit -> master)
// Modports: master (requester side), slave (the unit).
// ---------------------------------------------------------------------------
interface twos_comp_serial_unit_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [1:0]       in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_neg;
   logic             out_ovf;

   modport master (
      output in_valid, in_data, in_mode, out_ready,
      input  in_ready, out_valid, out_data, out_neg, out_ovf
   );

   modport slave (
      input  in_valid, in_data, in_mode, out_ready,
      output in_ready, out_valid, out_data, out_neg, out_ovf
   );
endinterface

// File: rtl/twos_comp_serial_unit_digit_adder.sv
// ---------------------------------------------------------------------------
// twos_comp_digit_adder
// Combinational DIGIT-wide conditional-invert adder:
//   sum_digit/cout = (op_digit ^ {DIGIT{inv}}) + cin
// Ports: op_digit (in), inv (in), cin (in), sum_digit (out), cout (out).
// ---------------------------------------------------------------------------
module twos_comp_digit_adder #(
   parameter int DIGIT = 8
) (
   input  logic [DIGIT-1:0] op_digit,
   input  logic             inv,
   input  logic             cin,
   output logic [DIGIT-1:0] sum_digit,
   output logic             cout
);
   logic [DIGIT:0] sum_s;

   assign sum_s     = {1'b0, op_digit ^ {DIGIT{inv}}} + {{DIGIT{1'b0}}, cin};
   assign sum_digit = sum_s[DIGIT-1:0];
   assign cout      = sum_s[DIGIT];
endmodule

// File: rtl/twos_comp_serial_unit.sv
// ---------------------------------------------------------------------------
// twos_comp_serial_unit
// Digit-serial two's-complement unit: PASS, NEG, ABS and sign-magnitude to
// two's-complement on one WIDTH-bit operand, DIGIT bits per cycle, LSB first.
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : twos_comp_serial_unit_if.slave (operand and result handshakes)
// Optional feature: define TWOS_COMP_OVF_DETECT_EN to flag NEG/ABS of the
// most-negative value on out_ovf; otherwise out_ovf is tied low.
// ---------------------------------------------------------------------------
module twos_comp_serial_unit
   import twos_comp_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIGIT = 8
) (
   input logic                  clock,
   input logic                  reset,
   twos_comp_serial_unit_if.slave bus
);
   localparam int NDIG  = WIDTH / DIGIT;
   localparam int IDX_W = idx_width(NDIG);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

   state_t           state_r;
   state_t           state_nxt_s;
   logic [WIDTH-1:0] op_r;
   logic [WIDTH-1:0] res_r;
   logic [WIDTH-1:0] out_data_r;
   logic             inv_r;
   logic             carry_r;
   logic [IDX_W-1:0] idx_r;
   logic             out_valid_r;
   logic             out_neg_r;

   logic             accept_s;
   logic             last_s;
   logic             inv_in_s;
   logic [WIDTH-1:0] op_in_s;
   logic [DIGIT-1:0] sum_s;
   logic             cout_s;
   logic [WIDTH-1:0] res_next_s;

   assign bus.in_ready  = (state_r == ST_IDLE) & reset;
   assign accept_s      = bus.in_valid & bus.in_ready;
   assign last_s        = (state_r == ST_RUN) && (idx_r == LAST_IDX);
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign bus.out_neg   = out_neg_r;

   twos_comp_digit_adder #(.DIGIT(DIGIT)) u_adder (
      .op_digit  (op_r[DIGIT-1:0]),
      .inv       (inv_r),
      .cin       (carry_r),
      .sum_digit (sum_s),
      .cout      (cout_s)
   );

   // New digit enters at the top; after NDIG digits the first one sits at the bottom.
   assign res_next_s = (res_r >> DIGIT) | (WIDTH'(sum_s) << (WIDTH - DIGIT));

   // Operand conditioning and invert decision at acceptance.
   always_comb begin
      op_in_s  = bus.in_data;
      inv_in_s = 1'b0;
      case (bus.in_mode)
         MODE_PASS:  inv_in_s = 1'b0;
         MODE_NEG:   inv_in_s = 1'b1;
         MODE_ABS:   inv_in_s = bus.in_data[WIDTH-1];
         MODE_SM2TC: begin
            inv_in_s = bus.in_data[WIDTH-1];
            op_in_s  = {1'b0, bus.in_data[WIDTH-2:0]};
         end
         default:    inv_in_s = 1'b0;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) state_nxt_s = ST_RUN;
            else          state_nxt_s = ST_IDLE;
         end
         ST_RUN: begin
            if (last_s) state_nxt_s = ST_DONE;
            else        state_nxt_s = ST_RUN;
         end
         ST_DONE: begin
            if (bus.out_ready) state_nxt_s = ST_IDLE;
            else               state_nxt_s = ST_DONE;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Operand/result shift registers, carry, digit index and result outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         op_r        <= {WIDTH{1'b0}};
         res_r       <= {WIDTH{1'b0}};
         out_data_r  <= {WIDTH{1'b0}};
         inv_r       <= 1'b0;
         carry_r     <= 1'b0;
         idx_r       <= {IDX_W{1'b0}};
         out_valid_r <= 1'b0;
         out_neg_r   <= 1'b0;
      end else if (accept_s) begin
         op_r    <= op_in_s;
         inv_r   <= inv_in_s;
         carry_r <= inv_in_s;
         idx_r   <= {IDX_W{1'b0}};
      end else if (state_r == ST_RUN) begin
         op_r    <= op_r >> DIGIT;
         res_r   <= res_next_s;
         carry_r <= cout_s;
         idx_r   <= idx_r + IDX_W'(1);
         if (last_s) begin
            out_data_r  <= res_next_s;
            out_neg_r   <= res_next_s[WIDTH-1];
            out_valid_r <= 1'b1;
         end
      end else if ((state_r == ST_DONE) && bus.out_ready) begin
         out_valid_r <= 1'b0;
      end
   end

`ifdef TWOS_COMP_OVF_DETECT_EN
   logic             zero_r;
   logic             ovf_r;
   logic [DIGIT-1:0] dig_shl_s;
   logic             top_only_s;

   // The top digit must be exactly its MSB with all lower digit bits clear.
   assign dig_shl_s  = op_r[DIGIT-1:0] << 1;
   assign top_only_s = op_r[DIGIT-1] & (dig_shl_s == {DIGIT{1'b0}});

   // Running all-lower-digits-zero flag and most-negative overflow flag.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         zero_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else if (accept_s) begin
         zero_r <= 1'b1;
         ovf_r  <= 1'b0;
      end else if (last_s) begin
         ovf_r <= inv_r & zero_r & top_only_s;
      end else if (state_r == ST_RUN) begin
         zero_r <= zero_r & (op_r[DIGIT-1:0] == {DIGIT{1'b0}});
      end
   end

   assign bus.out_ovf = ovf_r;
`else
   assign bus.out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_twos_comp_serial_unit.sv
// ---------------------------------------------------------------------------
// tb_twos_comp_serial_unit
// Drives three units (DIGIT = 8, 1, 32 on WIDTH = 32) with identical operand
// streams and checks results, latency, handshake behaviour and reset abort.
// ---------------------------------------------------------------------------
module tb_twos_comp_serial_unit;
   import twos_comp_pkg::*;

`ifdef TWOS_COMP_OVF_DETECT_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   typedef struct {
      logic [1:0]  mode;
      logic [31:0] din;
      logic [31:0] dout;
      logic        neg;
      logic        ovf;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   int   ndig_a [3] = '{4, 32, 1};
   int   first_a [3];
   vec_t vecs [12];

   twos_comp_serial_unit_if #(.WIDTH(32)) if8 ();
   twos_comp_serial_unit_if #(.WIDTH(32)) if1 ();
   twos_comp_serial_unit_if #(.WIDTH(32)) if32 ();

   twos_comp_serial_unit #(.WIDTH(32), .DIGIT(8))  u8  (.clock(clk), .reset(rst_n), .bus(if8));
   twos_comp_serial_unit #(.WIDTH(32), .DIGIT(1))  u1  (.clock(clk), .reset(rst_n), .bus(if1));
   twos_comp_serial_unit #(.WIDTH(32), .DIGIT(32)) u32 (.clock(clk), .reset(rst_n), .bus(if32));

   logic [31:0] od [3];
   logic        ov [3];
   logic        ir [3];
   logic        on [3];
   logic        of [3];

   assign od[0] = if8.out_data;   assign od[1] = if1.out_data;   assign od[2] = if32.out_data;
   assign ov[0] = if8.out_valid;  assign ov[1] = if1.out_valid;  assign ov[2] = if32.out_valid;
   assign ir[0] = if8.in_ready;   assign ir[1] = if1.in_ready;   assign ir[2] = if32.in_ready;
   assign on[0] = if8.out_neg;    assign on[1] = if1.out_neg;    assign on[2] = if32.out_neg;
   assign of[0] = if8.out_ovf;    assign of[1] = if1.out_ovf;    assign of[2] = if32.out_ovf;

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive_in(input logic v, input logic [1:0] m, input logic [31:0] d);
      if8.in_valid  = v;  if8.in_mode  = m;  if8.in_data  = d;
      if1.in_valid  = v;  if1.in_mode  = m;  if1.in_data  = d;
      if32.in_valid = v;  if32.in_mode = m;  if32.in_data = d;
   endtask

   task automatic set_ordy(input logic r);
      if8.out_ready = r;  if1.out_ready = r;  if32.out_ready = r;
   endtask

   // Offer one operand to all units; returns #1 after the accept edge.
   task automatic start_op(input logic [1:0] m, input logic [31:0] d, input string tag);
      @(negedge clk);
      drive_in(1'b1, m, d);
      set_ordy(1'b0);
      for (int k = 0; k < 3; k++) chk($sformatf("%s in_ready dut%0d", tag, k), 32'(ir[k]), 32'd1);
      @(posedge clk);
      #1;
      drive_in(1'b0, ~m, ~d);
      for (int k = 0; k < 3; k++) chk($sformatf("%s valid_at_accept dut%0d", tag, k), 32'(ov[k]), 32'd0);
   endtask

   // Count cycles after accept until each unit raises out_valid (bounded).
   task automatic wait_done(input string tag);
      for (int k = 0; k < 3; k++) first_a[k] = -1;
      for (int c = 1; c <= 34; c++) begin
         @(posedge clk);
         #1;
         for (int k = 0; k < 3; k++)
            if (ov[k] && (first_a[k] < 0)) first_a[k] = c;
      end
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s latency dut%0d", tag, k), 32'(first_a[k]), 32'(ndig_a[k]));
         chk($sformatf("%s valid_held dut%0d", tag, k), 32'(ov[k]), 32'd1);
      end
   endtask

   task automatic finish_op(input string tag);
      @(negedge clk);
      set_ordy(1'b1);
      @(posedge clk);
      #1;
      set_ordy(1'b0);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s valid_drop dut%0d", tag, k), 32'(ov[k]), 32'd0);
         chk($sformatf("%s ready_back dut%0d", tag, k), 32'(ir[k]), 32'd1);
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      start_op(v.mode, v.din, tag);
      wait_done(tag);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s data dut%0d", tag, k), od[k], v.dout);
         chk($sformatf("%s neg dut%0d", tag, k), 32'(on[k]), 32'(v.neg));
         chk($sformatf("%s ovf dut%0d", tag, k), 32'(of[k]), 32'(v.ovf & OVF_EN));
      end
      finish_op(tag);
      for (int k = 0; k < 3; k++) chk($sformatf("%s data_kept dut%0d", tag, k), od[k], v.dout);
   endtask

   initial begin
      vec_t v;
      vecs[0]  = '{MODE_NEG,   32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0};
      vecs[1]  = '{MODE_ABS,   32'hFFFF_FF85, 32'h0000_007B, 1'b0, 1'b0};
      vecs[2]  = '{MODE_ABS,   32'h0000_007B, 32'h0000_007B, 1'b0, 1'b0};
      vecs[3]  = '{MODE_PASS,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0};
      vecs[4]  = '{MODE_NEG,   32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1};
      vecs[5]  = '{MODE_NEG,   32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
      vecs[6]  = '{MODE_SM2TC, 32'h8000_0005, 32'hFFFF_FFFB, 1'b1, 1'b0};
      vecs[7]  = '{MODE_SM2TC, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0};
      vecs[8]  = '{MODE_SM2TC, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b0};
      vecs[9]  = '{MODE_ABS,   32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1};
      vecs[10] = '{MODE_PASS,  32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0};
      vecs[11] = '{MODE_NEG,   32'h0000_0100, 32'hFFFF_FF00, 1'b1, 1'b0};

      drive_in(1'b0, MODE_PASS, 32'h0000_0000);
      set_ordy(1'b0);

      // Reset state
      #12;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("reset in_ready dut%0d", k), 32'(ir[k]), 32'd0);
         chk($sformatf("reset out_valid dut%0d", k), 32'(ov[k]), 32'd0);
         chk($sformatf("reset out_data dut%0d", k), od[k], 32'h0000_0000);
         chk($sformatf("reset out_neg dut%0d", k), 32'(on[k]), 32'd0);
         chk($sformatf("reset out_ovf dut%0d", k), 32'(of[k]), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven vectors
      for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Stall in DONE with noisy operand inputs
      start_op(MODE_PASS, 32'h1234_5678, "stall");
      wait_done("stall");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         drive_in(1'(i % 2), 2'(i), 32'hA5A5_0000 | 32'(i));
         @(posedge clk);
         #1;
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("stall%0d data dut%0d", i, k), od[k], 32'h1234_5678);
            chk($sformatf("stall%0d valid dut%0d", i, k), 32'(ov[k]), 32'd1);
            chk($sformatf("stall%0d in_ready dut%0d", i, k), 32'(ir[k]), 32'd0);
         end
      end
      @(negedge clk);
      drive_in(1'b0, MODE_PASS, 32'h0000_0000);
      finish_op("stall");
      for (int k = 0; k < 3; k++) chk($sformatf("stall after data dut%0d", k), od[k], 32'h1234_5678);

      // Reset in the middle of RUN (DIGIT=8 unit at idx 2)
      start_op(MODE_NEG, 32'h1234_5678, "abort");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("abort out_valid dut%0d", k), 32'(ov[k]), 32'd0);
         chk($sformatf("abort in_ready dut%0d", k), 32'(ir[k]), 32'd0);
         chk($sformatf("abort out_data dut%0d", k), od[k], 32'h0000_0000);
      end
      @(negedge clk);
      rst_n = 1'b1;
      v = '{MODE_NEG, 32'h0000_0010, 32'hFFFF_FFF0, 1'b1, 1'b0};
      run_vec(v, "post_abort");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
